// File: rtl/spi_reg_ctrl_if.sv
// Bus bundle between the SPI byte shifter, the command sequencer and the register store.
// The sequencer connects through the slave modport; the shifter/store side uses master.
interface spi_reg_ctrl_if #(
  parameter int AW = 7
);
  logic          cs_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          tx_load;
  logic [7:0]    tx_data;
  logic          mem_wr;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          busy;
  logic          addr_err;

  modport slave (
    input  cs_n, rx_valid, rx_data, mem_rdata,
    output tx_load, tx_data, mem_wr, mem_rd, mem_addr, mem_wdata, busy, addr_err
  );

  modport master (
    output cs_n, rx_valid, rx_data, mem_rdata,
    input  tx_load, tx_data, mem_wr, mem_rd, mem_addr, mem_wdata, busy, addr_err
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI slave command sequencer: parses framed bytes into single/burst register writes and reads.
// Define SPI_CTRL_AUTOINC_EN to advance the address (with wrap) after every write and read.
module spi_reg_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_reg_ctrl_if.slave  bus
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, WDATA, RD_REQ, RD_WAIT, RD_LOAD, RD_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] addr_inc;
  logic          frame_err_q, frame_err_d;
  logic          addr_err_q, addr_err_d;
  logic          pending_q, pending_d;
  logic          busy_q, busy_d;
  logic          tx_load_q, tx_load_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          mem_wr_q, mem_wr_d;
  logic          mem_rd_q, mem_rd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic          cmd_in_range;

  assign cmd_in_range = (bus.rx_data[AW-1:0] <= LAST);

`ifdef SPI_CTRL_AUTOINC_EN
  assign addr_inc = (addr_q == LAST) ? '0 : addr_q + AW'(1);
`else
  assign addr_inc = addr_q;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    frame_err_d = frame_err_q;
    addr_err_d  = addr_err_q;
    pending_d   = pending_q;
    tx_load_d   = 1'b0;
    tx_data_d   = tx_data_q;
    mem_wr_d    = 1'b0;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    // Frame end wins over everything: any byte or read in flight is dropped.
    if (bus.cs_n) begin
      state_d   = IDLE;
      pending_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = CMD;
          pending_d = 1'b0;
        end
        CMD: begin
          if (bus.rx_valid) begin
            addr_d      = bus.rx_data[AW-1:0];
            frame_err_d = !cmd_in_range;
            if (!cmd_in_range) addr_err_d = 1'b1;
            if (bus.rx_data[7]) begin
              state_d = WDATA;
            end else begin
              state_d = RD_REQ;
              if (cmd_in_range) begin
                mem_rd_d   = 1'b1;
                mem_addr_d = bus.rx_data[AW-1:0];
              end
            end
          end
        end
        WDATA: begin
          if (bus.rx_valid && !frame_err_q) begin
            mem_wr_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = bus.rx_data;
            addr_d      = addr_inc;
          end
        end
        RD_REQ: begin
          state_d = RD_WAIT;
          if (bus.rx_valid) pending_d = 1'b1;
        end
        RD_WAIT: begin
          // Store data is valid now; out-of-range reads return zero.
          tx_data_d = frame_err_q ? 8'h00 : bus.mem_rdata;
          tx_load_d = 1'b1;
          state_d   = RD_LOAD;
          if (bus.rx_valid) pending_d = 1'b1;
        end
        RD_LOAD: begin
          addr_d  = addr_inc;
          state_d = RD_IDLE;
          if (bus.rx_valid) pending_d = 1'b1;
        end
        RD_IDLE: begin
          if (pending_q || bus.rx_valid) begin
            state_d   = RD_REQ;
            pending_d = pending_q && bus.rx_valid;
            if (!frame_err_q) begin
              mem_rd_d   = 1'b1;
              mem_addr_d = addr_q;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      frame_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      tx_load_q   <= 1'b0;
      tx_data_q   <= 8'h00;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      frame_err_q <= frame_err_d;
      addr_err_q  <= addr_err_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      tx_load_q   <= tx_load_d;
      tx_data_q   <= tx_data_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.tx_load   = tx_load_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: models the register store, logs DUT events,
// and compares them against expected writes / transmit bytes queued with the stimulus.
module tb_spi_reg_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 7;

  logic clk;
  logic rst_n;

  spi_reg_ctrl_if #(.AW(AW)) bus ();

  spi_reg_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register store model with one-cycle registered read
  logic [7:0] store [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_wr) store[bus.mem_addr[2:0]] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= store[bus.mem_addr[2:0]];
  end

  // Event log, written only by the monitor
  int            cyc;
  int            overlap_cnt;
  logic [AW-1:0] obs_wr_addr [$];
  logic [7:0]    obs_wr_data [$];
  logic [AW-1:0] obs_rd_addr [$];
  logic [7:0]    obs_tx_data [$];
  int            obs_tx_cyc  [$];
  int            obs_rx_cyc  [$];

  initial begin
    cyc = 0;
    overlap_cnt = 0;
  end

  always @(negedge clk) begin
    if (bus.mem_wr) begin
      obs_wr_addr.push_back(bus.mem_addr);
      obs_wr_data.push_back(bus.mem_wdata);
    end
    if (bus.mem_rd) obs_rd_addr.push_back(bus.mem_addr);
    if (bus.tx_load) begin
      obs_tx_data.push_back(bus.tx_data);
      obs_tx_cyc.push_back(cyc);
    end
    if (bus.rx_valid && !bus.cs_n) obs_rx_cyc.push_back(cyc);
    if (bus.mem_wr && bus.mem_rd) overlap_cnt = overlap_cnt + 1;
    cyc = cyc + 1;
  end

  // Scoreboard: expectations pushed with stimulus, popped when compared
  int            n_cmp;
  int            n_bad;
  logic [AW-1:0] exp_wr_addr [$];
  logic [7:0]    exp_wr_data [$];
  logic [7:0]    exp_tx      [$];

  // ---------------- stimulus helpers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    bus.cs_n = 1'b0;
    wait_cyc(2);
  endtask

  task automatic end_frame();
    @(posedge clk); #1;
    bus.cs_n = 1'b1;
    wait_cyc(3);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n        = 1'b0;
    bus.cs_n     = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    wait_cyc(3);
    n_cmp++;
    if ({bus.tx_load, bus.mem_wr, bus.mem_rd, bus.busy, bus.addr_err} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {bus.tx_load, bus.mem_wr, bus.mem_rd, bus.busy, bus.addr_err});
    end
    n_cmp++;
    if (bus.tx_data !== 8'h00 || bus.mem_wdata !== 8'h00 || bus.mem_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got tx=%h wd=%h addr=%h expected 00/00/00",
               bus.tx_data, bus.mem_wdata, bus.mem_addr);
    end
    rst_n = 1'b1;
    wait_cyc(1);
    $display("test_reset done");
  endtask

  task automatic test_idle();
    int wr0 = obs_wr_addr.size();
    int rd0 = obs_rd_addr.size();
    int tx0 = obs_tx_data.size();
    send_byte(8'h85);          // cs_n high: ignored
    wait_cyc(2);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_rx_busy: got %b expected 0", bus.busy);
    end
    start_frame();             // empty frame
    end_frame();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_frame_busy: got %b expected 0", bus.busy);
    end
    n_cmp++;
    if (obs_wr_addr.size() != wr0 || obs_rd_addr.size() != rd0 || obs_tx_data.size() != tx0) begin
      n_bad++;
      $display("FAIL empty_frame_events: got wr=%0d rd=%0d tx=%0d expected 0/0/0",
               obs_wr_addr.size() - wr0, obs_rd_addr.size() - rd0, obs_tx_data.size() - tx0);
    end
    $display("test_idle done");
  endtask

  task automatic test_write_single();
    int wr0 = obs_wr_addr.size();
    int k   = wr0;
    exp_wr_addr.push_back(7'd3);
    exp_wr_data.push_back(8'h5A);
    start_frame();
    send_byte(8'h83);
    send_byte(8'h5A);
    wait_cyc(2);
    end_frame();
    n_cmp++;
    if (obs_wr_addr.size() - wr0 != exp_wr_addr.size()) begin
      n_bad++;
      $display("FAIL wr_single_count: got %0d expected %0d", obs_wr_addr.size() - wr0, exp_wr_addr.size());
    end
    while (exp_wr_addr.size() > 0) begin
      logic [AW-1:0] ea = exp_wr_addr.pop_front();
      logic [7:0]    ed = exp_wr_data.pop_front();
      if (k < obs_wr_addr.size()) begin
        n_cmp++;
        if (obs_wr_addr[k] !== ea || obs_wr_data[k] !== ed) begin
          n_bad++;
          $display("FAIL wr_single: got addr=%0d data=%h expected addr=%0d data=%h",
                   obs_wr_addr[k], obs_wr_data[k], ea, ed);
        end
      end
      k++;
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_single_busy: got %b expected 0", bus.busy);
    end
    $display("test_write_single done");
  endtask

  task automatic test_read_single();
    int rd0 = obs_rd_addr.size();
    int tx0 = obs_tx_data.size();
    int rx0 = obs_rx_cyc.size();
    int k   = tx0;
    exp_tx.push_back(8'h5A);
    start_frame();
    send_byte(8'h03);
    wait_cyc(6);
    end_frame();
    n_cmp++;
    if (obs_rd_addr.size() - rd0 != 1) begin
      n_bad++;
      $display("FAIL rd_single_count: got %0d expected 1", obs_rd_addr.size() - rd0);
    end else begin
      n_cmp++;
      if (obs_rd_addr[rd0] !== 7'd3) begin
        n_bad++;
        $display("FAIL rd_single_addr: got %0d expected 3", obs_rd_addr[rd0]);
      end
    end
    n_cmp++;
    if (obs_tx_data.size() - tx0 != exp_tx.size()) begin
      n_bad++;
      $display("FAIL rd_single_tx_count: got %0d expected %0d", obs_tx_data.size() - tx0, exp_tx.size());
    end
    while (exp_tx.size() > 0) begin
      logic [7:0] e = exp_tx.pop_front();
      if (k < obs_tx_data.size()) begin
        n_cmp++;
        if (obs_tx_data[k] !== e) begin
          n_bad++;
          $display("FAIL rd_single_data: got %h expected %h", obs_tx_data[k], e);
        end
      end
      k++;
    end
    n_cmp++;
    if (obs_tx_cyc.size() <= tx0 || obs_rx_cyc.size() <= rx0) begin
      n_bad++;
      $display("FAIL rd_latency: got no tx_load/rx event expected latency 3");
    end else if (obs_tx_cyc[tx0] - obs_rx_cyc[rx0] != 3) begin
      n_bad++;
      $display("FAIL rd_latency: got %0d expected 3", obs_tx_cyc[tx0] - obs_rx_cyc[rx0]);
    end
    $display("test_read_single done");
  endtask

  task automatic test_burst();
    int wr0 = obs_wr_addr.size();
    int tx0 = obs_tx_data.size();
    int k   = wr0;
`ifdef SPI_CTRL_AUTOINC_EN
    exp_wr_addr.push_back(7'd6); exp_wr_data.push_back(8'h11);
    exp_wr_addr.push_back(7'd7); exp_wr_data.push_back(8'h22);
    exp_wr_addr.push_back(7'd0); exp_wr_data.push_back(8'h33);
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22); exp_tx.push_back(8'h33);
`else
    exp_wr_addr.push_back(7'd6); exp_wr_data.push_back(8'h11);
    exp_wr_addr.push_back(7'd6); exp_wr_data.push_back(8'h22);
    exp_wr_addr.push_back(7'd6); exp_wr_data.push_back(8'h33);
    exp_tx.push_back(8'h33); exp_tx.push_back(8'h33); exp_tx.push_back(8'h33);
`endif
    start_frame();
    send_byte(8'h86);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    wait_cyc(2);
    end_frame();
    n_cmp++;
    if (obs_wr_addr.size() - wr0 != exp_wr_addr.size()) begin
      n_bad++;
      $display("FAIL burst_wr_count: got %0d expected %0d", obs_wr_addr.size() - wr0, exp_wr_addr.size());
    end
    while (exp_wr_addr.size() > 0) begin
      logic [AW-1:0] ea = exp_wr_addr.pop_front();
      logic [7:0]    ed = exp_wr_data.pop_front();
      if (k < obs_wr_addr.size()) begin
        n_cmp++;
        if (obs_wr_addr[k] !== ea || obs_wr_data[k] !== ed) begin
          n_bad++;
          $display("FAIL burst_wr: got addr=%0d data=%h expected addr=%0d data=%h",
                   obs_wr_addr[k], obs_wr_data[k], ea, ed);
        end
      end
      k++;
    end

    start_frame();
    send_byte(8'h06);
    wait_cyc(5);
    send_byte(8'hFF);
    wait_cyc(5);
    send_byte(8'hFF);
    wait_cyc(5);
    end_frame();
    k = tx0;
    n_cmp++;
    if (obs_tx_data.size() - tx0 != exp_tx.size()) begin
      n_bad++;
      $display("FAIL burst_tx_count: got %0d expected %0d", obs_tx_data.size() - tx0, exp_tx.size());
    end
    while (exp_tx.size() > 0) begin
      logic [7:0] e = exp_tx.pop_front();
      if (k < obs_tx_data.size()) begin
        n_cmp++;
        if (obs_tx_data[k] !== e) begin
          n_bad++;
          $display("FAIL burst_tx[%0d]: got %h expected %h", k - tx0, obs_tx_data[k], e);
        end
      end
      k++;
    end
    $display("test_burst done");
  endtask

  task automatic test_back_to_back();
    int rd0 = obs_rd_addr.size();
    int tx0 = obs_tx_data.size();
    int k   = tx0;
`ifdef SPI_CTRL_AUTOINC_EN
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22);
`else
    exp_tx.push_back(8'h33); exp_tx.push_back(8'h33);
`endif
    start_frame();
    @(posedge clk); #1;
    bus.rx_valid = 1'b1; bus.rx_data = 8'h06;   // command
    @(posedge clk); #1;
    bus.rx_data = 8'hFF;                         // early dummy: held pending
    @(posedge clk); #1;
    bus.rx_data = 8'hFE;                         // second early dummy: dropped
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    wait_cyc(12);
    end_frame();
    n_cmp++;
    if (obs_rd_addr.size() - rd0 != 2) begin
      n_bad++;
      $display("FAIL b2b_rd_count: got %0d expected 2", obs_rd_addr.size() - rd0);
    end
    n_cmp++;
    if (obs_tx_data.size() - tx0 != exp_tx.size()) begin
      n_bad++;
      $display("FAIL b2b_tx_count: got %0d expected %0d", obs_tx_data.size() - tx0, exp_tx.size());
    end
    while (exp_tx.size() > 0) begin
      logic [7:0] e = exp_tx.pop_front();
      if (k < obs_tx_data.size()) begin
        n_cmp++;
        if (obs_tx_data[k] !== e) begin
          n_bad++;
          $display("FAIL b2b_tx[%0d]: got %h expected %h", k - tx0, obs_tx_data[k], e);
        end
      end
      k++;
    end
    n_cmp++;
    if (overlap_cnt != 0) begin
      n_bad++;
      $display("FAIL strobe_overlap: got %0d cycles expected 0", overlap_cnt);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_abort();
    int wr0 = obs_wr_addr.size();
    int tx0;
    int k;
    start_frame();
    @(posedge clk); #1;
    bus.rx_valid = 1'b1; bus.rx_data = 8'h01;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0; bus.cs_n = 1'b1;
    tx0 = obs_tx_data.size();
    wait_cyc(1);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_busy: got %b expected 0", bus.busy);
    end
    wait_cyc(6);
    n_cmp++;
    if (obs_tx_data.size() != tx0) begin
      n_bad++;
      $display("FAIL abort_tx_load: got %0d expected 0", obs_tx_data.size() - tx0);
    end
    // byte coinciding with cs_n rising must not be written
    start_frame();
    send_byte(8'h84);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1; bus.rx_data = 8'h77; bus.cs_n = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    wait_cyc(3);
    n_cmp++;
    if (obs_wr_addr.size() != wr0) begin
      n_bad++;
      $display("FAIL cs_high_rx_write: got %0d writes expected 0", obs_wr_addr.size() - wr0);
    end
    // next frame works normally
    tx0 = obs_tx_data.size();
    k = tx0;
    exp_tx.push_back(8'h5A);
    start_frame();
    send_byte(8'h03);
    wait_cyc(6);
    end_frame();
    n_cmp++;
    if (obs_tx_data.size() - tx0 != exp_tx.size()) begin
      n_bad++;
      $display("FAIL abort_recover_count: got %0d expected %0d", obs_tx_data.size() - tx0, exp_tx.size());
    end
    while (exp_tx.size() > 0) begin
      logic [7:0] e = exp_tx.pop_front();
      if (k < obs_tx_data.size()) begin
        n_cmp++;
        if (obs_tx_data[k] !== e) begin
          n_bad++;
          $display("FAIL abort_recover_data: got %h expected %h", obs_tx_data[k], e);
        end
      end
      k++;
    end
    $display("test_abort done");
  endtask

  task automatic test_range_err();
    int wr0 = obs_wr_addr.size();
    int rd0;
    int tx0;
    int k;
    start_frame();
    send_byte(8'h8A);
    send_byte(8'hFF);
    wait_cyc(2);
    end_frame();
    n_cmp++;
    if (obs_wr_addr.size() != wr0) begin
      n_bad++;
      $display("FAIL range_wr_count: got %0d expected 0", obs_wr_addr.size() - wr0);
    end
    n_cmp++;
    if (bus.addr_err !== 1'b1) begin
      n_bad++;
      $display("FAIL range_addr_err_wr: got %b expected 1", bus.addr_err);
    end
    rd0 = obs_rd_addr.size();
    tx0 = obs_tx_data.size();
    k   = tx0;
    exp_tx.push_back(8'h00);
    start_frame();
    send_byte(8'h0A);
    wait_cyc(6);
    end_frame();
    n_cmp++;
    if (obs_rd_addr.size() != rd0) begin
      n_bad++;
      $display("FAIL range_rd_count: got %0d expected 0", obs_rd_addr.size() - rd0);
    end
    n_cmp++;
    if (obs_tx_data.size() - tx0 != exp_tx.size()) begin
      n_bad++;
      $display("FAIL range_tx_count: got %0d expected %0d", obs_tx_data.size() - tx0, exp_tx.size());
    end
    while (exp_tx.size() > 0) begin
      logic [7:0] e = exp_tx.pop_front();
      if (k < obs_tx_data.size()) begin
        n_cmp++;
        if (obs_tx_data[k] !== e) begin
          n_bad++;
          $display("FAIL range_tx_data: got %h expected %h", obs_tx_data[k], e);
        end
      end
      k++;
    end
    n_cmp++;
    if (bus.addr_err !== 1'b1) begin
      n_bad++;
      $display("FAIL range_addr_err_sticky: got %b expected 1", bus.addr_err);
    end
    $display("test_range_err done");
  endtask

  task automatic test_async_reset();
    int tx0 = obs_tx_data.size();
    start_frame();
    send_byte(8'h02);        // now in RD_REQ with mem_rd high
    #2;
    rst_n = 1'b0;            // mid-cycle, away from any clock edge
    #1;
    n_cmp++;
    if ({bus.mem_rd, bus.busy, bus.addr_err, bus.tx_load} !== 4'b0) begin
      n_bad++;
      $display("FAIL async_reset: got rd/busy/err/load=%b expected 0000",
               {bus.mem_rd, bus.busy, bus.addr_err, bus.tx_load});
    end
    wait_cyc(5);
    n_cmp++;
    if (obs_tx_data.size() != tx0) begin
      n_bad++;
      $display("FAIL async_reset_tx: got %0d tx_load expected 0", obs_tx_data.size() - tx0);
    end
    bus.cs_n = 1'b1;
    rst_n = 1'b1;
    wait_cyc(2);
    $display("test_async_reset done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_idle();
    test_write_single();
    test_read_single();
    test_burst();
    test_back_to_back();
    test_abort();
    test_range_err();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
